// File: rtl/fetch_unit_if.sv
// fetch_unit_if -- bus bundle between fetch_unit and its environment.
//   Memory side : mem_address, mem_datain, mem_we (to RAM), mem_dataout (from RAM,
//                 combinational read of mem_address).
//   Decode side : instr, instr_pc, instr_valid (to decoder), instr_ready (from decoder).
//   Control     : redirect, redirect_pc (branch/jump request).
//   Data port   : dreq, dwe, daddr, dwdata (request), drdata, dack (completion).
// The master modport is the fetch unit; the slave modport is the RAM/decoder/LSU side.
interface fetch_unit_if;
  logic [14:0] mem_address;
  logic [7:0]  mem_datain;
  logic [7:0]  mem_dataout;
  logic        mem_we;
  logic [31:0] instr;
  logic [14:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [14:0] redirect_pc;
  logic        dreq;
  logic        dwe;
  logic [14:0] daddr;
  logic [7:0]  dwdata;
  logic [7:0]  drdata;
  logic        dack;

  modport master (
    output mem_address, mem_datain, mem_we,
    output instr, instr_pc, instr_valid,
    output drdata, dack,
    input  mem_dataout, instr_ready,
    input  redirect, redirect_pc,
    input  dreq, dwe, daddr, dwdata
  );

  modport slave (
    input  mem_address, mem_datain, mem_we,
    input  instr, instr_pc, instr_valid,
    input  drdata, dack,
    output mem_dataout, instr_ready,
    output redirect, redirect_pc,
    output dreq, dwe, daddr, dwdata
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit -- byte-serial instruction fetch sharing a single-port 8-bit RAM with
// a data access port.
//   clk   : single clock, rising edge.
//   reset : asynchronous active-high reset.
//   bus   : fetch_unit_if.master (RAM port, instruction output handshake, redirect,
//           data request/response).
// An instruction is assembled big-endian from four consecutive bytes at pc, one byte
// per cycle, then held in HOLD until the decoder accepts it. A data access takes the
// RAM for one cycle and stalls the byte fetch; redirect restarts fetch at a new pc.
module fetch_unit #(
  parameter logic [14:0] RESET_PC = 15'h0000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q;
  logic [14:0] pc_q;
  logic [31:0] instr_q;
  logic [14:0] instr_pc_q;
  logic        vld_q;
  logic [7:0]  drdata_q;
  logic        dack_q;

  logic        data_cyc;
  logic        capture;
  logic        accept;
  logic [14:0] mem_address_c;
  logic [7:0]  mem_datain_c;
  logic        mem_we_c;

  // Next-state and RAM port steering
  always_comb begin
    state_d       = state_q;
    // dreq is ignored during the dack cycle so a held request is not repeated.
    data_cyc      = bus.dreq & ~dack_q;
    capture       = 1'b0;
    accept        = 1'b0;
    mem_address_c = pc_q;
    mem_datain_c  = '0;
    mem_we_c      = 1'b0;

    if (state_q == FETCH)
      mem_address_c = pc_q + {13'd0, cnt_q};

    if (data_cyc) begin
      mem_address_c = bus.daddr;
      mem_datain_c  = bus.dwdata;
      // Gated by reset so an access interrupted by reset never writes.
      mem_we_c      = bus.dwe & ~reset;
    end

    case (state_q)
      FETCH: begin
        capture = ~data_cyc;
        if (capture && cnt_q == 2'd3)
          state_d = HOLD;
      end
      HOLD: begin
        accept = vld_q & bus.instr_ready;
        if (accept)
          state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Redirect wins over both byte capture and the decoder handshake.
    if (bus.redirect) begin
      state_d = FETCH;
      capture = 1'b0;
      accept  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= FETCH;
    else
      state_q <= state_d;
  end

  // Fetch datapath and data-port response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= 2'd0;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= RESET_PC;
      vld_q      <= 1'b0;
      drdata_q   <= '0;
      dack_q     <= 1'b0;
    end else begin
      dack_q <= data_cyc;
      if (data_cyc && !bus.dwe)
        drdata_q <= bus.mem_dataout;

      if (bus.redirect) begin
        pc_q  <= bus.redirect_pc;
        cnt_q <= 2'd0;
        vld_q <= 1'b0;
      end else begin
        if (capture) begin
          case (cnt_q)
            2'd0:    instr_q[31:24] <= bus.mem_dataout;
            2'd1:    instr_q[23:16] <= bus.mem_dataout;
            2'd2:    instr_q[15:8]  <= bus.mem_dataout;
            default: instr_q[7:0]   <= bus.mem_dataout;
          endcase
          if (cnt_q == 2'd3) begin
            vld_q      <= 1'b1;
            instr_pc_q <= pc_q;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        if (accept) begin
          vld_q <= 1'b0;
          pc_q  <= pc_q + 15'd4;
          cnt_q <= 2'd0;
        end
      end
    end
  end

  assign bus.mem_address = mem_address_c;
  assign bus.mem_datain  = mem_datain_c;
  assign bus.mem_we      = mem_we_c;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = vld_q;
  assign bus.drdata      = drdata_q;
  assign bus.dack        = dack_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- scoreboard bench for fetch_unit: directed scenarios followed by
// randomized ready/redirect/data traffic, checked against a byte-array memory model.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if bus ();
  fetch_unit_if bus2 ();

  fetch_unit #(.RESET_PC(15'h0000)) dut (.clk(clk), .reset(reset), .bus(bus));
  fetch_unit #(.RESET_PC(15'h7FFE)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  // RAM seen by the DUTs and the bench's own reference copy of its contents.
  logic [7:0] ram  [0:32767];
  logic [7:0] mref [0:32767];

  assign bus.mem_dataout  = ram[bus.mem_address];
  assign bus2.mem_dataout = ram[bus2.mem_address];
  always @(posedge clk) if (bus.mem_we) ram[bus.mem_address] <= bus.mem_datain;

  assign bus2.instr_ready = 1'b1;
  assign bus2.redirect    = 1'b0;
  assign bus2.redirect_pc = 15'h0;
  assign bus2.dreq        = 1'b0;
  assign bus2.dwe         = 1'b0;
  assign bus2.daddr       = 15'h0;
  assign bus2.dwdata      = 8'h0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit         ld;
    logic [14:0] addr;
    logic [7:0]  data;
  } dexp_t;
  dexp_t dq[$];

  logic [14:0] exp_pc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] mword(input logic [14:0] a);
    logic [14:0] a1, a2, a3;
    a1 = a + 15'd1;
    a2 = a + 15'd2;
    a3 = a + 15'd3;
    return {mref[a], mref[a1], mref[a2], mref[a3]};
  endfunction

  // Starts a one-cycle data access and records what it must produce.
  task automatic data_issue(input bit we, input logic [14:0] a, input logic [7:0] d);
    bus.dreq   = 1'b1;
    bus.dwe    = we;
    bus.daddr  = a;
    bus.dwdata = d;
    if (we) begin
      dq.push_back('{ld: 1'b0, addr: a, data: d});
      mref[a] = d;
    end else begin
      dq.push_back('{ld: 1'b1, addr: a, data: mref[a]});
    end
  endtask

  task automatic wait_valid(input int maxc, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.instr_valid && n < maxc);
  endtask

  // Monitor: compares every accepted instruction and every data completion.
  always @(negedge clk) begin
    if (reset) begin
      exp_pc = 15'h0000;
    end else begin
      chk("mem_we_datain", {23'd0, bus.mem_we, bus.mem_datain},
          (bus.dreq && !bus.dack) ? {23'd0, bus.dwe, bus.dwdata} : 32'd0);
      if (bus.dack) begin
        if (dq.size() == 0) begin
          chk("dack_unexpected", 32'd1, 32'd0);
        end else begin
          dexp_t e;
          e = dq.pop_front();
          if (e.ld) chk("load_drdata", {24'd0, bus.drdata}, {24'd0, e.data});
          else      chk("store_ram", {24'd0, ram[e.addr]}, {24'd0, e.data});
        end
      end
      if (bus.redirect) begin
        exp_pc = bus.redirect_pc;
      end else if (bus.instr_valid && bus.instr_ready) begin
        chk("instr_pc", {17'd0, bus.instr_pc}, {17'd0, exp_pc});
        chk("instr", bus.instr, mword(exp_pc));
        exp_pc = exp_pc + 15'd4;
      end
    end
  end

  // Wrap-around fetch from RESET_PC = 7FFE.
  initial begin
    int n;
    @(negedge reset);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_addr", {17'd0, bus2.mem_address}, {17'd0, 15'h7FFE + 15'(i)});
      @(posedge clk); #1;
    end
    n = 0;
    while (!bus2.instr_valid && n < 10) begin @(posedge clk); #1; n++; end
    chk("wrap_pc0", {17'd0, bus2.instr_pc}, 32'h7FFE);
    chk("wrap_instr0", bus2.instr, mword(15'h7FFE));
    @(posedge clk); #1;
    n = 0;
    while (!bus2.instr_valid && n < 10) begin @(posedge clk); #1; n++; end
    chk("wrap_pc1", {17'd0, bus2.instr_pc}, 32'h0002);
    chk("wrap_instr1", bus2.instr, mword(15'h0002));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] h_instr;
    logic [14:0] h_addr;
    bit stable;
    logic [7:0] old;

    for (int i = 0; i < 32768; i++) begin
      ram[i]  = 8'($urandom);
      mref[i] = ram[i];
    end
    begin
      logic [7:0] init [0:11];
      init = '{8'h04, 8'h01, 8'h00, 8'h09, 8'h05, 8'h01, 8'h00, 8'h0A,
               8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 12; i++) begin ram[i] = init[i]; mref[i] = init[i]; end
    end

    bus.instr_ready = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 15'h0;
    bus.dreq        = 1'b1;   // request held during reset must not write
    bus.dwe         = 1'b1;
    bus.daddr       = 15'h0200;
    bus.dwdata      = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_instr_pc", {17'd0, bus.instr_pc}, 32'd0);
    chk("rst_dack", {31'd0, bus.dack}, 32'd0);
    chk("rst_drdata", {24'd0, bus.drdata}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_ram", {24'd0, ram[15'h0200]}, {24'd0, mref[15'h0200]});
    chk("rst_instr_pc2", {17'd0, bus2.instr_pc}, 32'h7FFE);
    bus.dreq = 1'b0;
    bus.dwe  = 1'b0;

    // First fetch and back-to-back throughput
    @(negedge clk);
    reset = 1'b0;
    wait_valid(10, n);
    chk("latency", n, 4);
    chk("first_instr", bus.instr, 32'h04010009);
    wait_valid(10, n);
    chk("throughput", n, 5);
    chk("second_instr", bus.instr, 32'h0501000A);
    chk("second_pc", {17'd0, bus.instr_pc}, 32'd4);

    // Decoder back-pressure
    bus.instr_ready = 1'b0;
    bus.redirect = 1'b1; bus.redirect_pc = 15'h0000;
    @(posedge clk); #1;
    bus.redirect = 1'b0;
    wait_valid(10, n);
    chk("hold_latency", n, 4);
    h_instr = bus.instr;
    h_addr  = bus.mem_address;
    stable  = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!bus.instr_valid || bus.instr !== h_instr || bus.mem_address !== h_addr) stable = 1'b0;
    end
    chk("hold_stable", {31'd0, stable}, 32'd1);
    chk("hold_addr", {17'd0, h_addr}, 32'd0);
    bus.instr_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("release_addr", {17'd0, bus.mem_address}, 32'd4);

    // Store in the middle of a fetch
    bus.redirect = 1'b1; bus.redirect_pc = 15'h0000;
    @(posedge clk); #1;
    bus.redirect = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    data_issue(1'b1, 15'h0100, 8'hA5);
    #1;
    chk("store_we_high", {31'd0, bus.mem_we}, 32'd1);
    chk("store_addr", {17'd0, bus.mem_address}, 32'h0100);
    @(posedge clk); #1;
    chk("store_dack", {31'd0, bus.dack}, 32'd1);
    bus.dreq = 1'b0; bus.dwe = 1'b0;
    #1;
    chk("store_we_low", {31'd0, bus.mem_we}, 32'd0);
    chk("store_ram100", {24'd0, ram[15'h0100]}, 32'hA5);
    wait_valid(10, n);
    chk("store_stall", n, 2);
    chk("store_instr", bus.instr, 32'h04010009);

    // Load while holding an instruction
    bus.instr_ready = 1'b0;
    data_issue(1'b0, 15'h0003, 8'h00);
    @(posedge clk); #1;
    chk("load_dack", {31'd0, bus.dack}, 32'd1);
    chk("load_val", {24'd0, bus.drdata}, 32'h09);
    chk("load_valid_kept", {31'd0, bus.instr_valid}, 32'd1);
    bus.dreq = 1'b0;
    @(posedge clk); #1;
    chk("load_dack_pulse", {31'd0, bus.dack}, 32'd0);
    chk("load_valid_kept2", {31'd0, bus.instr_valid}, 32'd1);
    bus.instr_ready = 1'b1;

    // Redirect mid-fetch
    bus.redirect = 1'b1; bus.redirect_pc = 15'h0000;
    @(posedge clk); #1;
    bus.redirect = 1'b0;
    @(posedge clk); #1;
    bus.redirect = 1'b1; bus.redirect_pc = 15'h0008;
    @(posedge clk); #1;
    bus.redirect = 1'b0;
    chk("redir_valid", {31'd0, bus.instr_valid}, 32'd0);
    wait_valid(10, n);
    chk("redir_latency", n, 4);
    chk("redir_pc", {17'd0, bus.instr_pc}, 32'h8);
    chk("redir_instr", bus.instr, 32'h11223344);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        bus.redirect    = 1'b1;
        bus.redirect_pc = 15'($urandom_range(0, 32'h2FFF));
      end else begin
        bus.redirect = 1'b0;
      end
      if (bus.dreq && bus.dack) begin
        bus.dreq = 1'b0;
        bus.dwe  = 1'b0;
      end else if (!bus.dreq && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1)
          data_issue(1'b1, 15'h4000 + 15'($urandom_range(0, 255)), 8'($urandom));
        else
          data_issue(1'b0, 15'($urandom_range(0, 32767)), 8'h00);
      end
      @(posedge clk); #1;
    end
    bus.redirect = 1'b0;
    bus.instr_ready = 1'b1;
    if (bus.dreq && bus.dack) begin bus.dreq = 1'b0; bus.dwe = 1'b0; end
    repeat (3) @(posedge clk);
    #1;
    if (bus.dreq) begin bus.dreq = 1'b0; bus.dwe = 1'b0; end
    repeat (2) @(posedge clk);
    #1;
    chk("dq_drained", dq.size(), 0);

    // Reset during a store aborts it
    old = mref[15'h4100];
    bus.dreq = 1'b1; bus.dwe = 1'b1; bus.daddr = 15'h4100; bus.dwdata = old ^ 8'hFF;
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    bus.dreq = 1'b0; bus.dwe = 1'b0;
    chk("abort_ram", {24'd0, ram[15'h4100]}, {24'd0, old});
    chk("abort_dack", {31'd0, bus.dack}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_valid(10, n);
    chk("rerst_latency", n, 4);
    chk("rerst_pc", {17'd0, bus.instr_pc}, 32'd0);
    repeat (3) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 15'h0000, meaning the byte address of the first instruction fetched after reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port mem_address, output, 15, the RAM byte address.
REQ-005 The block SHALL have port mem_datain, output, 8, the RAM write data.
REQ-006 The block SHALL have port mem_dataout, input, 8, the RAM read data, valid combinationally in the same cycle as mem_address.
REQ-007 The block SHALL have port mem_we, output, 1, the RAM write enable.
REQ-008 The block SHALL have port instr, output, 32, the assembled instruction word.
REQ-009 The block SHALL have port instr_pc, output, 15, the address of the first byte of instr.
REQ-010 The block SHALL have port instr_valid, output, 1, meaning instr and instr_pc are valid.
REQ-011 The block SHALL have port instr_ready, input, 1, meaning the decoder accepts instr.
REQ-012 The block SHALL have ports redirect, input, 1, and redirect_pc, input, 15, which together form a branch/jump request.
REQ-013 The block SHALL have ports dreq, input, 1 (data access request), dwe, input, 1 (1=store, 0=load), daddr, input, 15, and dwdata, input, 8.
REQ-014 The block SHALL have ports drdata, output, 8 (load result) and dack, output, 1 (one-cycle data-access completion pulse).

Function
REQ-015 The block SHALL have states FETCH (holding a byte counter, cnt 0..3) and HOLD.
REQ-016 In a FETCH fetch cycle, the block SHALL drive mem_address = pc+cnt (mod 2^15) and mem_we=0, and SHALL capture mem_dataout at the rising edge.
REQ-017 Byte order SHALL be big-endian: the byte at pc goes to instr[31:24] and the byte at pc+3 goes to instr[7:0].
REQ-018 When cnt=3 is captured, the block SHALL set instr_valid=1 and instr_pc=pc and go to HOLD; instr SHALL be stable while instr_valid=1.
REQ-019 In HOLD, when instr_valid&instr_ready at an edge, the block SHALL clear instr_valid, set pc to pc+4 (mod 2^15) and cnt to 0, and go to FETCH.
REQ-020 Latency SHALL be 4 cycles from fetch start to instr_valid, and the throughput with instr_ready tied to 1 SHALL be one instruction per 5 cycles.
REQ-021 A data cycle SHALL occur in any cycle with dreq=1 and dack=0, in either state.
REQ-022 In a data cycle, the block SHALL drive mem_address=daddr, mem_we=dwe and mem_datain=dwdata.
REQ-023 At the edge ending a data cycle, the block SHALL load drdata with mem_dataout (loads only; drdata is unchanged on stores) and set dack=1 for exactly one cycle.
REQ-024 A data cycle SHALL stall fetch: no byte is captured and cnt is unchanged.
REQ-025 dreq SHALL be ignored while dack=1, so at most one data access occurs per 2 cycles; the requester drops dreq in the dack cycle.
REQ-026 Outside data cycles, the block SHALL drive mem_we=0 and mem_datain=0.
REQ-027 In HOLD, mem_address SHALL be pc.
REQ-028 When redirect=1 at an edge, from any state, the block SHALL set pc to redirect_pc, set cnt to 0, clear instr_valid, and go to FETCH, discarding partial bytes and any unaccepted instruction; redirect SHALL take priority over an instr_ready handshake in the same cycle.
REQ-029 When redirect and a data cycle coincide, the data access SHALL complete normally (dack pulses) and the redirect SHALL also take effect.
REQ-030 Fetch addresses SHALL wrap modulo 2^15, e.g. pc=15'h7FFE fetches bytes 7FFE, 7FFF, 0000, 0001, and the next pc is 15'h0002.

Reset
REQ-031 While reset=1, the block SHALL asynchronously set: state FETCH, cnt 0, pc RESET_PC, instr 0, instr_pc RESET_PC, instr_valid 0, drdata 0, dack 0.
REQ-032 During reset, mem_we SHALL be 0.
REQ-033 Reset asserted mid-fetch or mid-data-cycle SHALL abort the operation with no write performed after assertion.
REQ-034 The first fetch cycle SHALL be the first clock after reset deassertion.

Verification
REQ-035 RAM[0..3]=04,01,00,09, ready=1, reset released -> instr=32'h04010009, instr_pc=0, instr_valid rises after the 4th edge; next instr=32'h0501000A with instr_pc=4, given RAM[4..7]=05,01,00,0A.
REQ-036 instr_ready held 0 for 10 cycles after valid -> instr, instr_valid and mem_address stable with no further RAM reads advancing; ready=1 -> pc=4 fetch begins next cycle.
REQ-037 Store dreq=1, dwe=1, daddr=15'h0100, dwdata=8'hA5 at cnt=2 -> mem_we high for 1 cycle, RAM[0x100]=A5, dack pulses once, and instr is still correct, delayed by 1 cycle.
REQ-038 Load from 0x0003 while in HOLD -> drdata=8'h09 and dack=1 for one cycle, with instr_valid unaffected.
REQ-039 redirect=1 with redirect_pc=15'h0008 at cnt=1 -> instr_valid stays 0 and the next instr has instr_pc=8, built from RAM[8..11].
REQ-040 RESET_PC=15'h7FFE -> bytes read from 7FFE, 7FFF, 0000, 0001, instr_pc=7FFE, and the following instr_pc=15'h0002.
